// File: rtl/button_toggle_pulse.sv
// Debounces a raw push-button and emits a one-cycle toggle request per accepted press.
// Also exports the debounced level and a wrapping count of accepted presses.
module button_toggle_pulse #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_in,
    output logic             t_out,
    output logic             btn_level,
    output logic [CNT_W-1:0] press_count
);

    // state   | meaning
    // IDLE    | debounced level low, input agrees
    // ARM     | level low, counting high samples toward a press
    // PRESSED | debounced level high, input agrees
    // DISARM  | level high, counting low samples toward a release
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        PRESSED = 2'd2,
        DISARM  = 2'd3
    } state_t;

    localparam logic [15:0] STAB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    state_t           state_q, state_d;
    logic [15:0]      stab_q, stab_d;
    logic             t_out_q, t_out_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= IDLE;
            stab_q  <= 16'd0;
            t_out_q <= 1'b0;
            level_q <= 1'b0;
            count_q <= '0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
            state_q <= state_d;
            stab_q  <= stab_d;
            t_out_q <= t_out_d;
            level_q <= level_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stab_d  = stab_q;
        t_out_d = 1'b0;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    state_d = ARM;
                    stab_d  = 16'd1;
                end
            end
            ARM: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                    stab_d  = 16'd0;
                end else if (stab_q == STAB_LAST) begin
                    // The only place a press is accepted, so pulse and count together.
                    state_d = PRESSED;
                    stab_d  = 16'd0;
                    t_out_d = 1'b1;
                    count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    stab_d = stab_q + 16'd1;
                end
            end
            PRESSED: begin
                if (!sync2_q) begin
                    state_d = DISARM;
                    stab_d  = 16'd1;
                end
            end
            DISARM: begin
                if (sync2_q) begin
                    state_d = PRESSED;
                    stab_d  = 16'd0;
                end else if (stab_q == STAB_LAST) begin
                    state_d = IDLE;
                    stab_d  = 16'd0;
                end else begin
                    stab_d = stab_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                stab_d  = 16'd0;
            end
        endcase
        level_d = (state_d == PRESSED) || (state_d == DISARM);
    end

    assign t_out       = t_out_q;
    assign btn_level   = level_q;
    assign press_count = count_q;

endmodule

// File: tb/tb_button_toggle_pulse.sv
// Self-checking bench for button_toggle_pulse: directed vector tables, hand-written
// corner sequences, and random stimulus compared against a run-length reference model.
module tb_button_toggle_pulse;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_in = 1'b0;
    logic       t_out;
    logic       btn_level;
    logic [7:0] press_count;

    int passed = 0;
    int total  = 0;

    button_toggle_pulse #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_in      (btn_in),
        .t_out       (t_out),
        .btn_level   (btn_level),
        .press_count (press_count)
    );

    always #5 clk = ~clk;

    // Reference model: the button value seen by the debouncer lags btn_in by two
    // edges; a level change is accepted after D consecutive disagreeing samples.
    logic m_h0, m_h1, m_level, m_t;
    int   m_run, m_cnt;

    task automatic model_clear();
        m_h0 = 1'b0; m_h1 = 1'b0; m_level = 1'b0; m_t = 1'b0;
        m_run = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        logic s;
        s    = m_h1;
        m_h1 = m_h0;
        m_h0 = btn_in;
        m_t  = 1'b0;
        if (s != m_level) begin
            m_run++;
            if (m_run == D) begin
                m_level = s;
                m_run   = 0;
                if (s) begin
                    m_t   = 1'b1;
                    m_cnt = (m_cnt + 1) % 256;
                end
            end
        end else begin
            m_run = 0;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_clear();
        else model_edge();
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".t_out"}, int'(t_out), int'(m_t));
        check({tag, ".btn_level"}, int'(btn_level), int'(m_level));
        check({tag, ".press_count"}, int'(press_count), m_cnt);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_clear();
        for (int k = 0; k < 3; k++) begin
            btn_in = k[0];
            tick();
            check("in_reset.t_out", int'(t_out), 0);
            check("in_reset.btn_level", int'(btn_level), 0);
            check("in_reset.press_count", int'(press_count), 0);
        end
        btn_in = 1'b0;
        reset  = 1'b0;
    endtask

    typedef struct {
        logic btn;
        logic exp_t;
        logic exp_l;
        int   exp_c;
    } vec_t;

    vec_t clean_v[30];
    vec_t bounce_v[20];

    initial begin
        logic [4:0] pat;
        logic       tff;
        int         pulses;
        int         last_pulse;
        bit         seen;

        pat = 5'b01101;
        for (int i = 0; i < 30; i++) begin
            clean_v[i].btn   = (i < 20);
            clean_v[i].exp_t = (i == D + 1);
            clean_v[i].exp_l = (i >= D + 1) && (i < 20 + D + 1);
            clean_v[i].exp_c = (i >= D + 1) ? 1 : 0;
        end
        for (int i = 0; i < 20; i++) begin
            bounce_v[i].btn   = (i < 5) ? pat[i] : 1'b1;
            bounce_v[i].exp_t = (i == 10);
            bounce_v[i].exp_l = (i >= 10);
            bounce_v[i].exp_c = (i >= 10) ? 1 : 0;
        end

        model_clear();
        #1;
        check("reset.t_out", int'(t_out), 0);
        check("reset.btn_level", int'(btn_level), 0);
        check("reset.press_count", int'(press_count), 0);
        do_reset();

        // Clean press then release
        for (int i = 0; i < 30; i++) begin
            btn_in = clean_v[i].btn;
            tick();
            check($sformatf("clean[%0d].t_out", i), int'(t_out), int'(clean_v[i].exp_t));
            check($sformatf("clean[%0d].btn_level", i), int'(btn_level), int'(clean_v[i].exp_l));
            check($sformatf("clean[%0d].press_count", i), int'(press_count), clean_v[i].exp_c);
        end

        // Bounce on press
        do_reset();
        for (int i = 0; i < 20; i++) begin
            btn_in = bounce_v[i].btn;
            tick();
            check($sformatf("bounce[%0d].t_out", i), int'(t_out), int'(bounce_v[i].exp_t));
            check($sformatf("bounce[%0d].btn_level", i), int'(btn_level), int'(bounce_v[i].exp_l));
            check($sformatf("bounce[%0d].press_count", i), int'(press_count), bounce_v[i].exp_c);
        end

        // Release glitch while pressed
        for (int i = 0; i < 10; i++) begin
            btn_in = (i >= 2);
            tick();
            check("glitch.t_out", int'(t_out), 0);
            check("glitch.btn_level", int'(btn_level), 1);
            check("glitch.press_count", int'(press_count), 1);
        end

        // Async reset during the t_out cycle
        do_reset();
        btn_in = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = (t_out == 1'b1);
        end
        check("areset.pulse_seen", int'(seen), 1);
        #3;
        reset = 1'b1;
        model_clear();
        #1;
        check("areset.t_out", int'(t_out), 0);
        check("areset.btn_level", int'(btn_level), 0);
        check("areset.press_count", int'(press_count), 0);
        #2;
        reset = 1'b0;
        for (int k = 1; k <= D + 4; k++) begin
            tick();
            check($sformatf("areset.edge%0d.t_out", k), int'(t_out), (k == D + 2) ? 1 : 0);
            check_model("areset");
        end

        // Counter wrap over 256 presses, observed through a downstream T flip-flop
        do_reset();
        tff = 1'b0;
        pulses = 0;
        for (int p = 0; p < 256; p++) begin
            for (int k = 0; k < 16; k++) begin
                btn_in = (k < 8);
                tick();
                if (t_out) begin
                    tff = ~tff;
                    pulses++;
                end
                check_model("wrap");
            end
        end
        check("wrap.press_count", int'(press_count), 0);
        check("wrap.pulses", pulses, 256);
        check("wrap.tff_q", int'(tff), 0);

        // Random stimulus against the model
        do_reset();
        last_pulse = -1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 4) == 0) btn_in = ~btn_in;
            tick();
            check_model("rand");
            if (t_out) begin
                if (last_pulse >= 0)
                    check("rand.pulse_gap_ok", int'((c - last_pulse) >= 2 * D), 1);
                last_pulse = c;
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/button_toggle_pulse.md
BUTTON_TOGGLE_PULSE -- requirements
Module: button_toggle_pulse

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, giving the number of consecutive equal synchronized samples needed to accept a level change; legal range 2..65535.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of press_count.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port btn_in, input, 1 bit: raw asynchronous, bouncing push-button level.
REQ-006 The block SHALL have port t_out, output, 1 bit: registered one-cycle toggle-request pulse driving the T input of the downstream T flip-flop.
REQ-007 The block SHALL have port btn_level, output, 1 bit: registered debounced button level.
REQ-008 The block SHALL have port press_count, output, CNT_W bits: registered count of accepted presses.

Function
REQ-009 btn_in SHALL pass through a two-flop synchronizer (sync1, then sync2); the FSM samples only sync2.
REQ-010 The FSM SHALL have exactly four states: IDLE (stable low), ARM (candidate press), PRESSED (stable high), DISARM (candidate release).
REQ-011 IDLE with sync2=1 SHALL go to ARM with the stability counter set to 1; IDLE with sync2=0 SHALL hold.
REQ-012 ARM with sync2=0 SHALL return to IDLE with the counter cleared, producing no pulse.
REQ-013 ARM with sync2=1 and counter = DEBOUNCE_CYCLES-1 SHALL go to PRESSED; otherwise ARM with sync2=1 SHALL increment the counter.
REQ-014 PRESSED with sync2=0 SHALL go to DISARM with the counter set to 1; PRESSED with sync2=1 SHALL hold.
REQ-015 DISARM with sync2=1 SHALL return to PRESSED with the counter cleared, producing no pulse.
REQ-016 DISARM with sync2=0 and counter = DEBOUNCE_CYCLES-1 SHALL go to IDLE; otherwise DISARM with sync2=0 SHALL increment the counter.
REQ-017 t_out SHALL be 1 for exactly the one cycle following the ARM->PRESSED edge and 0 in every other cycle; release SHALL never pulse.
REQ-018 btn_level SHALL be 1 exactly when the state is PRESSED or DISARM.
REQ-019 press_count SHALL increment on the same edge that asserts t_out and SHALL wrap from 2^CNT_W-1 to 0.
REQ-020 Latency: with btn_in first sampled high at edge 0 and held, sync2 SHALL first be sampled at edge 2; t_out and btn_level SHALL rise at edge DEBOUNCE_CYCLES+1 (edge 5 with the default), and t_out SHALL fall at the next edge.
REQ-021 A glitch shorter than DEBOUNCE_CYCLES synchronized samples SHALL produce no t_out, no btn_level change and no press_count change.
REQ-022 Two accepted presses SHALL be separated by a full accepted release, so at least 2*DEBOUNCE_CYCLES cycles SHALL separate consecutive t_out pulses.

Reset
REQ-023 reset=1 SHALL immediately, without waiting for clk, force sync1=0, sync2=0, state=IDLE, counter=0, t_out=0, btn_level=0 and press_count=0.
REQ-024 Reset asserted mid-operation, including during the t_out cycle, SHALL abort the operation; after deassertion a button still held high SHALL be treated as a new press, with the full REQ-020 latency.
REQ-025 While reset is high, outputs SHALL hold their reset values regardless of btn_in.

Verification
REQ-026 Clean press: default parameters, btn_in 0->1 at edge 0 and held for 20 cycles -> t_out high only between edges 5 and 6, btn_level=1 from edge 5, press_count=1.
REQ-027 Bounce: btn_in pattern 1,0,1,1,0 over 5 cycles, then 1 held for 10 cycles -> exactly one t_out pulse, press_count=1, no pulse during the bounce.
REQ-028 Release glitch: while PRESSED, btn_in low for 2 cycles, then high again -> btn_level stays 1, no t_out pulse, press_count unchanged.
REQ-029 Wrap: CNT_W=8 with 256 clean press/release cycles -> press_count returns to 0; the downstream T flip-flop Q toggles 256 times and ends at its initial value.
REQ-030 Async reset: reset pulsed between clock edges in the t_out cycle -> t_out, btn_level and press_count become 0 before the next edge; with btn_in held high, t_out pulses again DEBOUNCE_CYCLES+2 edges after reset deasserts.
